// File: rtl/code_conv_pkg.sv
// Shared definitions for the code-converter scheduler: FSM state encoding and
// the default code width of the external converter.
package code_conv_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/code_converter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above ptr wins,
// otherwise the search wraps around to the lowest active requester.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  logic            hi_found;
  logic            lo_found;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;

  // NOTE: every variable written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Descending scan: the last hit is the lowest index in each region.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (ID_W'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    any       = lo_found;
    grant_idx = hi_found ? hi_idx : lo_idx;
    grant     = '0;
    if (lo_found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/code_converter_scheduler.sv
// Time-shares one external combinational code converter among N_REQ requesters
// and returns each result, tagged with the requester ID, on a valid/ready port.
module code_converter_scheduler
  import code_conv_pkg::*;
#(
  parameter  int WIDTH  = CODE_W,
  parameter  int N_REQ  = 2,
  parameter  int SETTLE = 1,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       conv_in,
  input  logic [WIDTH-1:0]       conv_out,
  output logic                   resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic [ID_W-1:0]        resp_id,
  input  logic                   resp_ready,
  output logic                   busy
);

  localparam int                CNT_W    = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             any;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             capture;
  logic             done;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // grant is all-zero when nobody requests, so no accept strobe leaks out.
        req_ready = grant;
        if (any) begin
          accept     = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_LAST) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_in    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      cnt        <= '0;
      ptr        <= '0;
    end else begin
      if (accept) begin
        conv_in <= sel_data;
        resp_id <= grant_idx;
        cnt     <= '0;
        ptr     <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
      if (state == ST_SETTLE) cnt <= cnt + CNT_W'(1);
      if (capture) begin
        resp_data  <= conv_out;
        resp_valid <= 1'b1;
      end
      if (done) resp_valid <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_code_converter_scheduler.sv
// Directed bench for code_converter_scheduler with an excess-3 converter model
// and per-instance response scoreboards (SETTLE=1 and SETTLE=3 instances).
module tb_code_converter_scheduler;

  typedef struct packed {
    logic [0:0] id;
    logic [3:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;

  logic [1:0] req_valid;
  logic [7:0] req_data;
  logic [1:0] req_ready;
  logic [3:0] conv_in;
  logic [3:0] conv_out;
  logic       resp_valid;
  logic [3:0] resp_data;
  logic [0:0] resp_id;
  logic       resp_ready;
  logic       busy;

  logic [1:0] req_valid3;
  logic [7:0] req_data3;
  logic [1:0] req_ready3;
  logic [3:0] conv_in3;
  logic [3:0] conv_out3;
  logic       resp_valid3;
  logic [3:0] resp_data3;
  logic [0:0] resp_id3;
  logic       resp_ready3;
  logic       busy3;

  exp_t q[$];
  exp_t q3[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic       hold = 1'b0;
  logic [3:0] hold_data;
  logic [0:0] hold_id;

  always #5 clk = ~clk;

  // BCD -> excess-3 converter model.
  assign conv_out  = conv_in + 4'd3;
  assign conv_out3 = conv_in3 + 4'd3;

  code_converter_scheduler #(.WIDTH(4), .N_REQ(2), .SETTLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .conv_in    (conv_in),
    .conv_out   (conv_out),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  code_converter_scheduler #(.WIDTH(4), .N_REQ(2), .SETTLE(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid3),
    .req_data   (req_data3),
    .req_ready  (req_ready3),
    .conv_in    (conv_in3),
    .conv_out   (conv_out3),
    .resp_valid (resp_valid3),
    .resp_data  (resp_data3),
    .resp_id    (resp_id3),
    .resp_ready (resp_ready3),
    .busy       (busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at a negedge. Requesters drop valid after their accept edge unless
  // kept; returns at posedge+1 once every expected response has been consumed.
  task automatic drain(input logic [1:0] keep, input int bound);
    logic [1:0] acc;
    int n;
    n = 0;
    forever begin
      acc = req_valid & req_ready;
      tick();
      req_valid = req_valid & ~(acc & ~keep);
      n++;
      if (q.size() == 0 || n >= bound) break;
      @(negedge clk);
    end
    check("drain_done", q.size(), 0);
  endtask

  // Protocol checks and scoreboard for the SETTLE=1 instance.
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (req_ready != 2'b00) begin
        check("rdy_only_idle", busy, 0);
        check("rdy_onehot", $onehot(req_ready), 1);
        check("rdy_has_valid", req_ready & ~req_valid, 0);
      end
      if (hold) begin
        check("hold_valid", resp_valid, 1);
        check("hold_data", resp_data, hold_data);
        check("hold_id", resp_id, hold_id);
      end
      if (resp_valid && resp_ready) begin
        check("sb_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("sb_data", resp_data, e.data);
          check("sb_id", resp_id, e.id);
        end
      end
      hold      = resp_valid && !resp_ready;
      hold_data = resp_data;
      hold_id   = resp_id;
    end
  end

  // Scoreboard for the SETTLE=3 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready3 != 2'b00) check("rdy3_only_idle", busy3, 0);
      if (resp_valid3 && resp_ready3) begin
        check("sb3_expected", q3.size() != 0, 1);
        if (q3.size() != 0) begin
          exp_t e;
          e = q3.pop_front();
          check("sb3_data", resp_data3, e.data);
          check("sb3_id", resp_id3, e.id);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 2'b00;
    req_data    = 8'h00;
    resp_ready  = 1'b1;
    req_valid3  = 2'b00;
    req_data3   = 8'h00;
    resp_ready3 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state of both instances.
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_conv_in", conv_in, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst3_busy", busy3, 0);

    // 1: single request, one-cycle settle.
    tick();
    req_valid = 2'b01;
    req_data  = 8'h05;
    q.push_back('{id: 1'b0, data: 4'h8});
    @(negedge clk);
    check("t1_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_conv_in", conv_in, 4'h5);
    check("t1_not_yet", resp_valid, 0);
    check("t1_ready_off", req_ready, 2'b00);
    tick();
    @(negedge clk);
    check("t1_valid", resp_valid, 1);
    check("t1_data", resp_data, 4'h8);
    check("t1_id", resp_id, 0);
    tick();
    @(negedge clk);
    check("t1_released", resp_valid, 0);
    check("t1_idle", busy, 0);
    check("t1_conv_hold", conv_in, 4'h5);

    // 2: simultaneous requests from a fresh pointer, twice.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_data  = {4'h7, 4'h2};
    req_valid = 2'b11;
    q.push_back('{id: 1'b0, data: 4'h5});
    q.push_back('{id: 1'b1, data: 4'hA});
    @(negedge clk);
    drain(2'b00, 100);
    req_valid = 2'b11;
    q.push_back('{id: 1'b0, data: 4'h5});
    q.push_back('{id: 1'b1, data: 4'hA});
    @(negedge clk);
    check("t2_first_again", req_ready, 2'b01);
    drain(2'b00, 100);

    // 3: response back-pressure with a competing request pending.
    req_data   = {4'h4, 4'h3};
    req_valid  = 2'b01;
    resp_ready = 1'b0;
    q.push_back('{id: 1'b0, data: 4'h6});
    q.push_back('{id: 1'b1, data: 4'h7});
    @(negedge clk);
    check("t3_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    @(negedge clk);
    check("t3_settle_ready", req_ready, 2'b00);
    tick();
    repeat (5) begin
      @(negedge clk);
      check("t3_valid", resp_valid, 1);
      check("t3_data", resp_data, 4'h6);
      check("t3_id", resp_id, 0);
      check("t3_ready_off", req_ready, 2'b00);
      check("t3_busy", busy, 1);
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("t3_still_valid", resp_valid, 1);
    tick();
    @(negedge clk);
    check("t3_fell", resp_valid, 0);
    check("t3_next_grant", req_ready, 2'b10);
    drain(2'b00, 100);

    // 5: reset during SETTLE, then during RESP.
    req_data  = 8'h01;
    req_valid = 2'b01;
    @(negedge clk);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("t5_in_settle", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5a_valid", resp_valid, 0);
    check("t5a_conv_in", conv_in, 0);
    check("t5a_busy", busy, 0);
    tick();
    req_valid  = 2'b01;
    resp_ready = 1'b0;
    @(negedge clk);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("t5_in_resp", resp_valid, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5b_valid", resp_valid, 0);
    check("t5b_conv_in", conv_in, 0);
    check("t5b_busy", busy, 0);
    tick();
    resp_ready = 1'b1;
    req_data   = {4'h7, 4'h2};
    req_valid  = 2'b11;
    q.push_back('{id: 1'b0, data: 4'h5});
    q.push_back('{id: 1'b1, data: 4'hA});
    @(negedge clk);
    check("t5_grant0", req_ready, 2'b01);
    drain(2'b00, 100);

    // 6: requester 1 always valid, requester 0 pulses; both keep being served.
    req_data  = {4'h9, 4'h0};
    req_valid = 2'b10;
    for (int r = 0; r < 3; r++) begin
      logic [3:0] d0;
      d0 = (r == 0) ? 4'h0 : (r == 1) ? 4'h4 : 4'h6;
      q.push_back('{id: 1'b1, data: 4'hC});
      q.push_back('{id: 1'b1, data: 4'hC});
      @(negedge clk);
      drain(2'b10, 100);
      req_data[3:0] = d0;
      req_valid     = 2'b11;
      q.push_back('{id: 1'b0, data: d0 + 4'd3});
      q.push_back('{id: 1'b1, data: 4'hC});
      @(negedge clk);
      drain(2'b10, 100);
    end
    req_valid = 2'b00;

    // 4: SETTLE=3 latency on the second instance.
    req_data3  = {4'h9, 4'h0};
    req_valid3 = 2'b10;
    q3.push_back('{id: 1'b1, data: 4'hC});
    @(negedge clk);
    check("t4_ready", req_ready3, 2'b10);
    tick();
    req_valid3 = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_wait", resp_valid3, 0);
      tick();
    end
    @(negedge clk);
    check("t4_valid", resp_valid3, 1);
    check("t4_data", resp_data3, 4'hC);
    check("t4_id", resp_id3, 1);
    tick();
    @(negedge clk);
    check("t4_fell", resp_valid3, 0);
    check("t4_idle", busy3, 0);

    repeat (2) tick();
    check("sb_empty", q.size(), 0);
    check("sb3_empty", q3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
